// File: rtl/word_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : word_buffer_pkg
// Description : Shared constants, status encodings and helpers for the
//               word buffer and the registered data stage it feeds.
// Revision    : 1.0 - initial release
// ============================================================================
package word_buffer_pkg;

   // Defaults shared with the downstream registered stage
   localparam int c_DEFAULT_WIDTH = 8;
   localparam int c_DEFAULT_DEPTH = 4;
   localparam int c_DEFAULT_AW    = 2;

   // Buffer occupancy status
   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } state_t;

   // Map an occupancy count onto the status encoding
   function automatic state_t state_from_count(input int cnt, input int depth);
      state_t st;
      if (cnt == 0) begin
         st = ST_EMPTY;
      end else if (cnt == depth) begin
         st = ST_FULL;
      end else begin
         st = ST_PARTIAL;
      end
      return st;
   endfunction

endpackage : word_buffer_pkg
`default_nettype wire

// File: rtl/word_buffer_mem.sv
`default_nettype none
// ============================================================================
// Module      : word_buffer_mem
// Description : DEPTH x WIDTH storage array, one synchronous write port and
//               one asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module word_buffer_mem
   import word_buffer_pkg::*;
#(
   parameter int WIDTH = c_DEFAULT_WIDTH,
   parameter int DEPTH = c_DEFAULT_DEPTH,
   parameter int AW    = c_DEFAULT_AW
) (
   input  logic             clock,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Write the addressed entry on an accepted push
   always_ff @(posedge clock) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = r_mem[rd_addr];

endmodule : word_buffer_mem
`default_nettype wire

// File: rtl/word_buffer.sv
`default_nettype none
// ============================================================================
// Module      : word_buffer
// Description : Small valid/ready buffer feeding a registered data stage with
//               an enable pulse plus data, honouring downstream back-pressure.
//               Storage is always in the path; a pushed word leaves at the
//               earliest on the following edge.
// Revision    : 1.0 - initial release
// ============================================================================
module word_buffer
   import word_buffer_pkg::*;
#(
   parameter int WIDTH = c_DEFAULT_WIDTH,
   parameter int DEPTH = c_DEFAULT_DEPTH,
   parameter int AW    = c_DEFAULT_AW
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             out_ready,
   output logic             out_enable,
   output logic [WIDTH-1:0] out_d,
   output logic [AW:0]      count,
   output logic             overflow
);

   state_t           r_state;
   state_t           w_next_state;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic [AW:0]      w_next_count;
   logic             w_push;
   logic             w_pop;
   logic [WIDTH-1:0] w_rd_data;
   logic             r_out_enable;
   logic [WIDTH-1:0] r_out_d;
   logic             r_overflow;

   // Ready comes only from registered state, so out_ready never reaches in_ready
   assign in_ready = (r_state != ST_FULL);

   // Clear dominates: no transfer is honoured in a clearing cycle
   assign w_push = in_valid && in_ready && !clear;
   assign w_pop  = (r_state != ST_EMPTY) && out_ready && !clear;

   word_buffer_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clock   (clock),
      .wr_en   (w_push),
      .wr_addr (r_wr_ptr),
      .wr_data (in_data),
      .rd_addr (r_rd_ptr),
      .rd_data (w_rd_data)
   );

   // Next occupancy and status derived from it
   always_comb begin
      w_next_count = r_count;
      w_next_state = r_state;
      if (clear) begin
         w_next_count = '0;
         w_next_state = ST_EMPTY;
      end else begin
         w_next_count = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
         w_next_state = state_from_count(int'(w_next_count), DEPTH);
      end
   end

   // Status state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Pointers and count; pointers wrap naturally at AW bits
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= w_next_count;
      end
   end

   // Output register: one-cycle enable pulse, data held between pulses
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_out_enable <= 1'b0;
         r_out_d      <= '0;
      end else if (clear) begin
         r_out_enable <= 1'b0;
         r_out_d      <= '0;
      end else begin
         r_out_enable <= w_pop;
         if (w_pop) begin
            r_out_d <= w_rd_data;
         end
      end
   end

   // Sticky flag for words dropped while not ready
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_overflow <= 1'b0;
      end else if (in_valid && !in_ready) begin
         r_overflow <= 1'b1;
      end
   end

   assign out_enable = r_out_enable;
   assign out_d      = r_out_d;
   assign count      = r_count;
   assign overflow   = r_overflow;

endmodule : word_buffer
`default_nettype wire

// File: tb/tb_word_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_word_buffer
// Description : Directed self-checking bench for word_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_word_buffer;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic             clock;
   logic             reset;
   logic             clear;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_ready;
   logic             out_enable;
   logic [WIDTH-1:0] out_d;
   logic [AW:0]      count;
   logic             overflow;

   int checks;
   int passed;

   word_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_ready  (out_ready),
      .out_enable (out_enable),
      .out_d      (out_d),
      .count      (count),
      .overflow   (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle away from it
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hAA;
      out_ready = 1'b0;
      step();
      step();
      checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else passed++;
      checks++; if (out_enable !== 1'b0) $display("FAIL rst_out_enable: got %b expected 0", out_enable); else passed++;
      checks++; if (out_d !== 8'h00) $display("FAIL rst_out_d: got %h expected 00", out_d); else passed++;
      checks++; if (count !== 3'd0) $display("FAIL rst_count: got %0d expected 0", count); else passed++;
      checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b expected 0", overflow); else passed++;
      in_valid = 1'b0;
      reset    = 1'b1;
      step();
      checks++; if (count !== 3'd0) $display("FAIL rel_count: got %0d expected 0", count); else passed++;
      checks++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready: got %b expected 1", in_ready); else passed++;
      checks++; if (out_enable !== 1'b0) $display("FAIL rel_out_enable: got %b expected 0", out_enable); else passed++;
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h11;
      step();
      in_valid = 1'b0;
      checks++; if (count !== 3'd1) $display("FAIL single_count1: got %0d expected 1", count); else passed++;
      checks++; if (out_enable !== 1'b0) $display("FAIL single_no_bypass: got %b expected 0", out_enable); else passed++;
      step();
      checks++; if (out_enable !== 1'b1) $display("FAIL single_pulse: got %b expected 1", out_enable); else passed++;
      checks++; if (out_d !== 8'h11) $display("FAIL single_d: got %h expected 11", out_d); else passed++;
      checks++; if (count !== 3'd0) $display("FAIL single_count0: got %0d expected 0", count); else passed++;
      step();
      checks++; if (out_enable !== 1'b0) $display("FAIL single_pulse_end: got %b expected 0", out_enable); else passed++;
      checks++; if (out_d !== 8'h11) $display("FAIL single_hold: got %h expected 11", out_d); else passed++;
   endtask

   task automatic test_fill_overflow();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_data = 8'(i);
         step();
      end
      checks++; if (count !== 3'd4) $display("FAIL fill_count: got %0d expected 4", count); else passed++;
      checks++; if (in_ready !== 1'b0) $display("FAIL fill_ready: got %b expected 0", in_ready); else passed++;
      checks++; if (overflow !== 1'b0) $display("FAIL fill_ovf_early: got %b expected 0", overflow); else passed++;
      in_data = 8'h05;
      step();
      in_valid = 1'b0;
      checks++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b expected 1", overflow); else passed++;
      checks++; if (count !== 3'd4) $display("FAIL ovf_count: got %0d expected 4", count); else passed++;
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         checks++; if (out_enable !== 1'b1) $display("FAIL drain_pulse%0d: got %b expected 1", i, out_enable); else passed++;
         checks++; if (out_d !== 8'(i)) $display("FAIL drain_d%0d: got %h expected %h", i, out_d, 8'(i)); else passed++;
         if (i == 1) begin
            checks++; if (in_ready !== 1'b1) $display("FAIL drain_ready: got %b expected 1", in_ready); else passed++;
         end
      end
      step();
      checks++; if (out_enable !== 1'b0) $display("FAIL drain_idle: got %b expected 0", out_enable); else passed++;
      checks++; if (count !== 3'd0) $display("FAIL drain_count: got %0d expected 0", count); else passed++;
      checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow); else passed++;
      checks++; if (out_d !== 8'h04) $display("FAIL drain_hold: got %h expected 04", out_d); else passed++;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hA0;
      step();
      in_data = 8'hA1;
      step();
      checks++; if (count !== 3'd2) $display("FAIL b2b_prefill: got %0d expected 2", count); else passed++;
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_data = 8'hA2 + 8'(k);
         step();
         checks++; if (count !== 3'd2) $display("FAIL b2b_count%0d: got %0d expected 2", k, count); else passed++;
         checks++; if (out_enable !== 1'b1) $display("FAIL b2b_pulse%0d: got %b expected 1", k, out_enable); else passed++;
         checks++; if (out_d !== 8'hA0 + 8'(k)) $display("FAIL b2b_d%0d: got %h expected %h", k, out_d, 8'hA0 + 8'(k)); else passed++;
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_d !== 8'hAA) $display("FAIL b2b_tail0: got %h expected AA", out_d); else passed++;
      step();
      checks++; if (out_d !== 8'hAB) $display("FAIL b2b_tail1: got %h expected AB", out_d); else passed++;
      checks++; if (count !== 3'd0) $display("FAIL b2b_empty: got %0d expected 0", count); else passed++;
      step();
      checks++; if (out_enable !== 1'b0) $display("FAIL b2b_idle: got %b expected 0", out_enable); else passed++;
   endtask

   task automatic test_clear();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'hC1 + 8'(i);
         step();
      end
      checks++; if (count !== 3'd3) $display("FAIL clr_pre_count: got %0d expected 3", count); else passed++;
      checks++; if (overflow !== 1'b1) $display("FAIL clr_pre_ovf: got %b expected 1", overflow); else passed++;
      clear     = 1'b1;
      in_data   = 8'hEE;
      out_ready = 1'b1;
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      checks++; if (count !== 3'd0) $display("FAIL clr_count: got %0d expected 0", count); else passed++;
      checks++; if (out_enable !== 1'b0) $display("FAIL clr_enable: got %b expected 0", out_enable); else passed++;
      checks++; if (out_d !== 8'h00) $display("FAIL clr_d: got %h expected 00", out_d); else passed++;
      checks++; if (overflow !== 1'b0) $display("FAIL clr_ovf: got %b expected 0", overflow); else passed++;
      checks++; if (in_ready !== 1'b1) $display("FAIL clr_ready: got %b expected 1", in_ready); else passed++;
      step();
      checks++; if (out_enable !== 1'b0) $display("FAIL clr_not_stored: got %b expected 0", out_enable); else passed++;
      checks++; if (count !== 3'd0) $display("FAIL clr_count_after: got %0d expected 0", count); else passed++;
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'hD1 + 8'(i);
         step();
      end
      in_valid = 1'b0;
      checks++; if (count !== 3'd3) $display("FAIL ares_pre_count: got %0d expected 3", count); else passed++;
      #2;
      reset = 1'b0;
      #1;
      checks++; if (count !== 3'd0) $display("FAIL ares_count: got %0d expected 0", count); else passed++;
      checks++; if (in_ready !== 1'b1) $display("FAIL ares_ready: got %b expected 1", in_ready); else passed++;
      checks++; if (out_enable !== 1'b0) $display("FAIL ares_enable: got %b expected 0", out_enable); else passed++;
      checks++; if (overflow !== 1'b0) $display("FAIL ares_ovf: got %b expected 0", overflow); else passed++;
      step();
      reset     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h5A;
      step();
      in_valid = 1'b0;
      checks++; if (count !== 3'd1) $display("FAIL ares_push: got %0d expected 1", count); else passed++;
      step();
      checks++; if (out_enable !== 1'b1) $display("FAIL ares_first_pulse: got %b expected 1", out_enable); else passed++;
      checks++; if (out_d !== 8'h5A) $display("FAIL ares_first_d: got %h expected 5A", out_d); else passed++;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      test_reset();
      test_single();
      test_fill_overflow();
      test_back_to_back();
      test_clear();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_word_buffer
`default_nettype wire
